// File: rtl/m65c02_int_pkg.sv
// m65c02_int_pkg: shared constants for the M65C02 vectored interrupt controller
//  Default vector addresses, the BRK mode code, the Cfg_Sel register map and
//  a clog2 helper for sizing index fields.
package m65c02_int_pkg;

    localparam logic [15:0] VEC_BASE_DEF = 16'hFFE0;
    localparam logic [15:0] NMI_VEC_DEF  = 16'hFFFA;
    localparam logic [15:0] RST_VEC_DEF  = 16'hFFFC;
    localparam logic [15:0] BRK_VEC_DEF  = 16'hFFFE;
    localparam logic [2:0]  BRK_MODE_DEF = 3'b010;

    typedef enum logic [1:0] {
        CFG_EN   = 2'd0,
        CFG_EDGE = 2'd1,
        CFG_W1C  = 2'd2,
        CFG_NOP  = 2'd3
    } cfg_sel_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/m65c02_int_sync.sv
// m65c02_int_sync: two-FF synchroniser with falling-edge pulse, reset to inactive (1)
//  Rst  in  1   asynchronous active-high reset
//  Clk  in  1   clock
//  n_in in  pW  asynchronous active-low inputs
//  sync out pW  synchronised level (second FF)
//  fall out pW  one-cycle pulse: sync low now, high one cycle earlier
module m65c02_int_sync #(
    parameter int pW = 9
) (
    input  logic          Rst,
    input  logic          Clk,
    input  logic [pW-1:0] n_in,
    output logic [pW-1:0] sync,
    output logic [pW-1:0] fall
);

    logic [pW-1:0] s1, s3;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1   <= '1;
            sync <= '1;
            s3   <= '1;
        end else begin
            s1   <= n_in;
            sync <= s1;
            s3   <= sync;
        end
    end

    assign fall = s3 & ~sync;

endmodule

// File: rtl/m65c02_vec_int_ctrl.sv
// m65c02_vec_int_ctrl: vectored multi-source interrupt controller for the M65C02 core
//  Rst/Clk          asynchronous active-high reset, clock
//  nNMI, nIRQ       asynchronous active-low NMI (falling edge) and maskable requests
//  Mode, IRQ_Msk    core mode (BRK detection) and I flag
//  IntSvc           core has fetched the vector; clears the serviced source
//  Cfg_WE/Sel/DI    config writes: enable, edge-mode, write-1-to-clear pending
//  En, Edge, Pend   config and pending registers
//  Int, Vector      request and vector to the core; Int_Id = selected source
//  NMI, IRQ, Brk    NMI pending, any enabled maskable pending, registered BRK
module m65c02_vec_int_ctrl
    import m65c02_int_pkg::*;
#(
    parameter int          pN_IRQ      = 8,
    parameter logic [15:0] pVEC_BASE   = VEC_BASE_DEF,
    parameter logic [15:0] pNMI_Vector = NMI_VEC_DEF,
    parameter logic [15:0] pRST_Vector = RST_VEC_DEF,
    parameter logic [15:0] pBRK_Vector = BRK_VEC_DEF,
    parameter logic [2:0]  pBRK        = BRK_MODE_DEF
) (
    input  logic              Rst,
    input  logic              Clk,
    input  logic              nNMI,
    input  logic [pN_IRQ-1:0] nIRQ,
    input  logic [2:0]        Mode,
    input  logic              IRQ_Msk,
    input  logic              IntSvc,
    input  logic              Cfg_WE,
    input  logic [1:0]        Cfg_Sel,
    input  logic [pN_IRQ-1:0] Cfg_DI,
    output logic [pN_IRQ-1:0] En,
    output logic [pN_IRQ-1:0] Edge,
    output logic [pN_IRQ-1:0] Pend,
    output logic              Int,
    output logic [15:0]       Vector,
    output logic [3:0]        Int_Id,
    output logic              NMI,
    output logic              IRQ,
    output logic              Brk
);

    logic [pN_IRQ:0]   s2, fall;
    logic [pN_IRQ-1:0] clr, edge_chg, pend_nxt, act;
    logic [3:0]        id_nxt;
    logic [15:0]       vec_nxt;
    logic              any, nmi_sel, nmi_set;

    // NMI rides in the top bit so one synchroniser covers every pin
    m65c02_int_sync #(.pW(pN_IRQ + 1)) u_sync (
        .Rst  (Rst),
        .Clk  (Clk),
        .n_in ({nNMI, nIRQ}),
        .sync (s2),
        .fall (fall)
    );

    assign nmi_set = fall[pN_IRQ] & ~s2[pN_IRQ];

    always_comb begin
        clr      = '0;
        pend_nxt = '0;
        id_nxt   = Int_Id;
        edge_chg = (Cfg_WE && Cfg_Sel == CFG_EDGE) ? (Cfg_DI ^ Edge) : '0;
        act      = Pend & En;
        any      = |act;
        for (int i = 0; i < pN_IRQ; i++) begin
            // nmi_sel is frozen with Int_Id, so the clear hits the source actually vectored
            clr[i]      = (IntSvc & ~nmi_sel & (Int_Id == 4'(i))) | (Cfg_WE && Cfg_Sel == CFG_W1C && Cfg_DI[i]);
            pend_nxt[i] = edge_chg[i] ? 1'b0 : Edge[i] ? (fall[i] | (Pend[i] & ~clr[i])) : ~s2[i];
        end
        for (int i = pN_IRQ - 1; i >= 0; i--)
            if (act[i]) id_nxt = 4'(i);
        vec_nxt = NMI ? pNMI_Vector
                : (~IRQ_Msk & any) ? pVEC_BASE + {11'd0, id_nxt, 1'b0}
                : Brk ? pBRK_Vector : pRST_Vector;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            En      <= '0;
            Edge    <= '0;
            Pend    <= '0;
            NMI     <= 1'b0;
            IRQ     <= 1'b0;
            Brk     <= 1'b0;
            Int     <= 1'b0;
            Int_Id  <= 4'd0;
            Vector  <= pRST_Vector;
            nmi_sel <= 1'b0;
        end else begin
            En   <= (Cfg_WE && Cfg_Sel == CFG_EN) ? Cfg_DI : En;
            Edge <= (Cfg_WE && Cfg_Sel == CFG_EDGE) ? Cfg_DI : Edge;
            Pend <= pend_nxt;
            NMI  <= nmi_set | (NMI & ~(IntSvc & nmi_sel));
            IRQ  <= any;
            Brk  <= (Mode == pBRK);
            Int  <= NMI | (~IRQ_Msk & any);
            // selection holds through the service cycle
            if (!IntSvc) begin
                Vector  <= vec_nxt;
                Int_Id  <= id_nxt;
                nmi_sel <= NMI;
            end
        end
    end

endmodule

// File: tb/tb_m65c02_vec_int_ctrl.sv
// tb_m65c02_vec_int_ctrl: directed self-checking bench for m65c02_vec_int_ctrl
module tb_m65c02_vec_int_ctrl;

    logic        Rst, Clk, nNMI, IntSvc, IRQ_Msk, Cfg_WE;
    logic [7:0]  nIRQ, Cfg_DI;
    logic [2:0]  Mode;
    logic [1:0]  Cfg_Sel;
    logic [7:0]  En, Edge, Pend;
    logic        Int, NMI, IRQ, Brk;
    logic [15:0] Vector;
    logic [3:0]  Int_Id;
    int          total = 0;
    int          bad = 0;

    m65c02_vec_int_ctrl dut (
        .Rst(Rst), .Clk(Clk), .nNMI(nNMI), .nIRQ(nIRQ), .Mode(Mode),
        .IRQ_Msk(IRQ_Msk), .IntSvc(IntSvc), .Cfg_WE(Cfg_WE), .Cfg_Sel(Cfg_Sel),
        .Cfg_DI(Cfg_DI), .En(En), .Edge(Edge), .Pend(Pend), .Int(Int),
        .Vector(Vector), .Int_Id(Int_Id), .NMI(NMI), .IRQ(IRQ), .Brk(Brk)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [7:0] d);
        Cfg_WE = 1'b1; Cfg_Sel = sel; Cfg_DI = d;
        tick();
        Cfg_WE = 1'b0; Cfg_Sel = 2'd3; Cfg_DI = 8'h00;
    endtask

    task automatic svc();
        IntSvc = 1'b1;
        tick();
        IntSvc = 1'b0;
        tick();
    endtask

    // one cycle low on the selected pins, ending just after the first edge that samples it
    task automatic pulse(input logic nmi, input logic [7:0] m);
        nNMI = ~nmi; nIRQ = ~m;
        tick();
        nNMI = 1'b1; nIRQ = 8'hFF;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".En"},   {8'h0, En},     16'h0000);
        chk({tag, ".Edge"}, {8'h0, Edge},   16'h0000);
        chk({tag, ".Pend"}, {8'h0, Pend},   16'h0000);
        chk({tag, ".NMI"},  {15'h0, NMI},   16'h0000);
        chk({tag, ".IRQ"},  {15'h0, IRQ},   16'h0000);
        chk({tag, ".Brk"},  {15'h0, Brk},   16'h0000);
        chk({tag, ".Int"},  {15'h0, Int},   16'h0000);
        chk({tag, ".Id"},   {12'h0, Int_Id}, 16'h0000);
        chk({tag, ".Vec"},  Vector,         16'hFFFC);
    endtask

    initial begin
        Rst = 1'b1; nNMI = 1'b1; nIRQ = 8'hFF; Mode = 3'd0; IRQ_Msk = 1'b0;
        IntSvc = 1'b0; Cfg_WE = 1'b0; Cfg_Sel = 2'd3; Cfg_DI = 8'h00;
        tick(2);
        chk_reset("rst0");
        Rst = 1'b0;
        tick();

        // 1: single edge source, latency and service
        cfg(2'd0, 8'hFF);
        cfg(2'd1, 8'hFF);
        chk("t1.En",   {8'h0, En},   16'h00FF);
        chk("t1.Edge", {8'h0, Edge}, 16'h00FF);
        pulse(1'b0, 8'h08);
        tick();
        chk("t1.pend_n1", {8'h0, Pend}, 16'h0000);
        tick();
        chk("t1.pend_n2", {8'h0, Pend}, 16'h0008);
        chk("t1.int_n2",  {15'h0, Int}, 16'h0000);
        tick();
        chk("t1.int_n3", {15'h0, Int},    16'h0001);
        chk("t1.vec",    Vector,          16'hFFE6);
        chk("t1.id",     {12'h0, Int_Id}, 16'h0003);
        IntSvc = 1'b1;
        tick();
        IntSvc = 1'b0;
        chk("t1.pend_clr", {8'h0, Pend}, 16'h0000);
        chk("t1.int_svc",  {15'h0, Int}, 16'h0001);
        tick();
        chk("t1.int_off", {15'h0, Int}, 16'h0000);
        chk("t1.vec_off", Vector,       16'hFFFC);

        // 2: NMI beats maskable sources; lowest index next
        pulse(1'b1, 8'h24);
        tick(2);
        chk("t2.nmi",  {15'h0, NMI},  16'h0001);
        chk("t2.pend", {8'h0, Pend},  16'h0024);
        tick();
        chk("t2.int",  {15'h0, Int},  16'h0001);
        chk("t2.vec0", Vector,        16'hFFFA);
        svc();
        chk("t2.vec1",    Vector,          16'hFFE4);
        chk("t2.id1",     {12'h0, Int_Id}, 16'h0002);
        chk("t2.nmi_clr", {15'h0, NMI},    16'h0000);
        svc();
        chk("t2.vec2", Vector,          16'hFFEA);
        chk("t2.id2",  {12'h0, Int_Id}, 16'h0005);
        svc();
        chk("t2.int_off", {15'h0, Int},  16'h0000);
        chk("t2.pend0",   {8'h0, Pend},  16'h0000);

        // 3: level source 0 survives IntSvc and drops 3 cycles after release
        cfg(2'd1, 8'hFE);
        nIRQ = 8'hFE;
        tick(3);
        chk("t3.pend", {8'h0, Pend}, 16'h0001);
        tick();
        chk("t3.int", {15'h0, Int},    16'h0001);
        chk("t3.vec", Vector,          16'hFFE0);
        chk("t3.id",  {12'h0, Int_Id}, 16'h0000);
        svc();
        chk("t3.int_svc",  {15'h0, Int}, 16'h0001);
        chk("t3.pend_svc", {8'h0, Pend}, 16'h0001);
        nIRQ = 8'hFF;
        tick(3);
        chk("t3.int_m2", {15'h0, Int}, 16'h0001);
        tick();
        chk("t3.int_m3", {15'h0, Int}, 16'h0000);
        cfg(2'd1, 8'hFF);

        // 4: mask blocks Int but not IRQ; BRK vector when nothing unmasked
        IRQ_Msk = 1'b1;
        pulse(1'b0, 8'h02);
        tick(3);
        chk("t4.pend", {8'h0, Pend}, 16'h0002);
        chk("t4.int",  {15'h0, Int}, 16'h0000);
        chk("t4.irq",  {15'h0, IRQ}, 16'h0001);
        chk("t4.vec",  Vector,       16'hFFFC);
        Mode = 3'b010;
        tick(2);
        chk("t4.brk",     {15'h0, Brk}, 16'h0001);
        chk("t4.vec_brk", Vector,       16'hFFFE);
        Mode = 3'd0; IRQ_Msk = 1'b0;
        tick(2);
        chk("t4.brk_off", {15'h0, Brk},    16'h0000);
        chk("t4.int_on",  {15'h0, Int},    16'h0001);
        chk("t4.vec_irq", Vector,          16'hFFE2);
        chk("t4.id",      {12'h0, Int_Id}, 16'h0001);
        cfg(2'd2, 8'h02);
        chk("t4.w1c", {8'h0, Pend}, 16'h0000);
        tick();
        chk("t4.int_off", {15'h0, Int}, 16'h0000);

        // 5: new edge in the IntSvc cycle wins over the clear
        pulse(1'b0, 8'h10);
        tick(3);
        chk("t5.int", {15'h0, Int},    16'h0001);
        chk("t5.id",  {12'h0, Int_Id}, 16'h0004);
        chk("t5.vec", Vector,          16'hFFE8);
        pulse(1'b0, 8'h10);
        tick();
        IntSvc = 1'b1;
        tick();
        IntSvc = 1'b0;
        chk("t5.pend_kept", {8'h0, Pend}, 16'h0010);
        tick();
        chk("t5.reint", {15'h0, Int},    16'h0001);
        chk("t5.id2",   {12'h0, Int_Id}, 16'h0004);
        cfg(2'd2, 8'h10);
        chk("t5.w1c", {8'h0, Pend}, 16'h0000);
        tick();
        chk("t5.int_off", {15'h0, Int}, 16'h0000);

        // 6: asynchronous reset with work outstanding
        Mode = 3'b010;
        pulse(1'b1, 8'h40);
        tick(3);
        chk("t6.nmi",  {15'h0, NMI},  16'h0001);
        chk("t6.pend", {8'h0, Pend},  16'h0040);
        chk("t6.brk",  {15'h0, Brk},  16'h0001);
        chk("t6.irq",  {15'h0, IRQ},  16'h0001);
        #2;
        Rst = 1'b1;
        #1;
        chk_reset("t6");
        Mode = 3'd0;
        tick();
        Rst = 1'b0;
        tick(2);
        chk("t6.vec_after", Vector, 16'hFFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
